// File: rtl/playfield_line_clear_ctrl.sv
// Row-clear and compaction sequencer for the playfield map.
// Scans rows bottom-up, moves surviving rows down, zero-fills the top and updates the score.
module playfield_line_clear_ctrl #(
    parameter int ROWS      = 20,
    parameter int COLS      = 10,
    parameter int CELL_W    = 5,
    parameter int ROW_W     = 5,
    parameter int SCORE_W   = 14,
    parameter int SCORE_MAX = 9999
) (
    input  logic                     VGA_CLK,
    input  logic                     RESET,
    input  logic                     start,
    input  logic                     new_game,
    output logic                     busy,
    output logic                     done,
    output logic [ROW_W-1:0]         rd_row,
    input  logic [COLS*CELL_W-1:0]   rd_data,
    output logic                     wr_en,
    output logic [ROW_W-1:0]         wr_row,
    output logic [COLS*CELL_W-1:0]   wr_data,
    output logic [4:0]               lines_cleared,
    output logic [SCORE_W-1:0]       score,
    output logic [SCORE_W-1:0]       best_score
);

    typedef enum logic [2:0] {IDLE, RD, EVAL, CLR, DONE} state_t;

    localparam logic [ROW_W-1:0]   LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [SCORE_W:0]   MAX_EXT  = (SCORE_W + 1)'(SCORE_MAX);

    state_t             state, state_n;
    logic [ROW_W-1:0]   src, src_n;
    logic [ROW_W-1:0]   dst, dst_n;
    logic [4:0]         cnt, cnt_n;
    logic [ROW_W-1:0]   rd_row_n;
    logic               row_full;
    logic [3:0]         points;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] new_score;

    always_comb begin
        row_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (rd_data[c*CELL_W +: CELL_W] == '0) begin
                row_full = 1'b0;
            end
        end
    end

    always_ff @(posedge VGA_CLK or posedge RESET) begin
        if (RESET) begin
            state  <= IDLE;
            src    <= '0;
            dst    <= '0;
            cnt    <= '0;
            rd_row <= '0;
        end else begin
            state  <= state_n;
            src    <= src_n;
            dst    <= dst_n;
            cnt    <= cnt_n;
            rd_row <= rd_row_n;
        end
    end

    // dst never drops below src, so every write lands on a row that has already been read.
    always_comb begin
        state_n  = state;
        src_n    = src;
        dst_n    = dst;
        cnt_n    = cnt;
        rd_row_n = rd_row;
        wr_en    = 1'b0;
        wr_row   = dst;
        wr_data  = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n  = RD;
                    src_n    = LAST_ROW;
                    dst_n    = LAST_ROW;
                    cnt_n    = '0;
                    rd_row_n = LAST_ROW;
                end
            end
            RD: begin
                state_n = EVAL;
            end
            EVAL: begin
                if (row_full) begin
                    cnt_n = cnt + 5'd1;
                end else begin
                    if (dst != src) begin
                        wr_en   = 1'b1;
                        wr_data = rd_data;
                    end
                    dst_n = dst - 1'b1;
                end
                if (src == '0) begin
                    state_n = (cnt_n != '0) ? CLR : DONE;
                end else begin
                    src_n    = src - 1'b1;
                    rd_row_n = src - 1'b1;
                    state_n  = RD;
                end
            end
            CLR: begin
                wr_en = 1'b1;
                if (dst == '0) begin
                    state_n = DONE;
                end else begin
                    dst_n = dst - 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        case (cnt)
            5'd0:    points = 4'd0;
            5'd1:    points = 4'd1;
            5'd2:    points = 4'd3;
            5'd3:    points = 4'd5;
            default: points = 4'd8;
        endcase
        score_sum = {1'b0, score} + {{(SCORE_W - 3){1'b0}}, points};
        new_score = (score_sum > MAX_EXT) ? MAX_EXT[SCORE_W-1:0] : score_sum[SCORE_W-1:0];
    end

    // new_game clears the score even in DONE, but best_score still sees the pass result.
    always_ff @(posedge VGA_CLK or posedge RESET) begin
        if (RESET) begin
            lines_cleared <= '0;
            score         <= '0;
            best_score    <= '0;
        end else if (state == DONE) begin
            lines_cleared <= cnt;
            score         <= new_game ? '0 : new_score;
            if (new_score > best_score) begin
                best_score <= new_score;
            end
        end else if (new_game) begin
            score <= '0;
        end
    end

endmodule

// File: tb/tb_playfield_line_clear_ctrl.sv
// Directed bench for playfield_line_clear_ctrl with a behavioural map model.
module tb_playfield_line_clear_ctrl;

    localparam int ROWS = 20;
    localparam int RW   = 50;
    localparam int MAXC = 300;

    logic           VGA_CLK = 1'b0;
    logic           RESET;
    logic           start;
    logic           new_game;
    logic           busy;
    logic           done;
    logic [4:0]     rd_row;
    logic [RW-1:0]  rd_data;
    logic           wr_en;
    logic [4:0]     wr_row;
    logic [RW-1:0]  wr_data;
    logic [4:0]     lines_cleared;
    logic [13:0]    score;
    logic [13:0]    best_score;

    logic           tb_we;
    logic           tb_clear;
    logic [4:0]     tb_row;
    logic [RW-1:0]  tb_data;
    logic [RW-1:0]  map [0:31];

    int tests  = 0;
    int failed = 0;
    int wr_count = 0;
    int done_count = 0;

    playfield_line_clear_ctrl dut (
        .VGA_CLK       (VGA_CLK),
        .RESET         (RESET),
        .start         (start),
        .new_game      (new_game),
        .busy          (busy),
        .done          (done),
        .rd_row        (rd_row),
        .rd_data       (rd_data),
        .wr_en         (wr_en),
        .wr_row        (wr_row),
        .wr_data       (wr_data),
        .lines_cleared (lines_cleared),
        .score         (score),
        .best_score    (best_score)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    // Map storage: one-cycle read latency, write sampled at the clock edge.
    always @(posedge VGA_CLK) begin
        rd_data <= map[rd_row];
        if (tb_clear) begin
            for (int i = 0; i < 32; i++) map[i] <= '0;
        end else if (tb_we) begin
            map[tb_row] <= tb_data;
        end else if (wr_en) begin
            map[wr_row] <= wr_data;
        end
        if (wr_en) wr_count <= wr_count + 1;
        if (done) done_count <= done_count + 1;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        assert (act === exp) else begin
            failed++;
            $error("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] full_row(input logic [4:0] v);
        logic [RW-1:0] r;
        for (int c = 0; c < 10; c++) r[c*5 +: 5] = v;
        return r;
    endfunction

    task automatic clear_map();
        tb_clear = 1'b1;
        @(negedge VGA_CLK);
        tb_clear = 1'b0;
    endtask

    task automatic set_row(input int r, input logic [RW-1:0] d);
        tb_we   = 1'b1;
        tb_row  = 5'(r);
        tb_data = d;
        @(negedge VGA_CLK);
        tb_we   = 1'b0;
    endtask

    task automatic fill_full(input int n);
        for (int r = ROWS - 1; r >= ROWS - n; r--) set_row(r, full_row(5'd3));
    endtask

    // Starts a pass and counts cycles from the accept edge to the done cycle.
    // ng_cycle > 0 pulses new_game in that cycle; ng_cycle == 0 pulses it in the DONE cycle.
    task automatic applyStimulus(input int ng_cycle, output int cycles, output int gaps,
                                 output logic [13:0] score_mid);
        int n;
        bit seen;
        n = 0;
        seen = 0;
        gaps = 0;
        score_mid = '1;
        @(negedge VGA_CLK);
        start = 1'b1;
        @(posedge VGA_CLK);
        while (!seen && n < MAXC) begin
            @(negedge VGA_CLK);
            start = 1'b0;
            n++;
            new_game = (ng_cycle > 0 && n == ng_cycle);
            if (n == ng_cycle + 1) score_mid = score;
            if (!busy) gaps++;
            if (done) begin
                seen = 1;
                if (ng_cycle == 0) new_game = 1'b1;
            end
        end
        cycles = seen ? n : -1;
        @(negedge VGA_CLK);
        new_game = 1'b0;
    endtask

    initial begin
        int cyc;
        int gaps;
        int wr0;
        int dn0;
        int n;
        logic [13:0] smid;
        logic [RW-1:0] p_row, q_row, a_row, b_row;

        p_row = full_row(5'd6);
        p_row[15 +: 5] = 5'd0;
        q_row = '0;
        q_row[45 +: 5] = 5'd31;
        a_row = '0;
        a_row[0 +: 5] = 5'd7;
        b_row = full_row(5'd9);
        b_row[0 +: 5] = 5'd0;
        b_row[20 +: 5] = 5'd0;

        RESET = 1'b1;
        start = 1'b0;
        new_game = 1'b0;
        tb_we = 1'b0;
        tb_clear = 1'b0;
        tb_row = '0;
        tb_data = '0;
        repeat (2) @(negedge VGA_CLK);
        clear_map();
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset wr_en", wr_en, 0);
        checkOutput("reset rd_row", rd_row, 0);
        checkOutput("reset score", score, 0);
        checkOutput("reset best", best_score, 0);
        checkOutput("reset lines", lines_cleared, 0);
        RESET = 1'b0;
        @(negedge VGA_CLK);

        // T1: empty map
        wr0 = wr_count;
        applyStimulus(-1, cyc, gaps, smid);
        checkOutput("T1 cycles", cyc, 41);
        checkOutput("T1 busy gaps", gaps, 0);
        checkOutput("T1 writes", wr_count - wr0, 0);
        checkOutput("T1 lines", lines_cleared, 0);
        checkOutput("T1 score", score, 0);

        // T2: one full row at the bottom
        set_row(19, full_row(5'd1));
        set_row(18, p_row);
        set_row(17, q_row);
        wr0 = wr_count;
        applyStimulus(-1, cyc, gaps, smid);
        checkOutput("T2 cycles", cyc, 42);
        checkOutput("T2 writes", wr_count - wr0, 20);
        checkOutput("T2 row19", map[19], p_row);
        checkOutput("T2 row18", map[18], q_row);
        n = 0;
        for (int r = 0; r < 18; r++) if (map[r] != '0) n++;
        checkOutput("T2 empty rows", n, 0);
        checkOutput("T2 lines", lines_cleared, 1);
        checkOutput("T2 score", score, 1);
        checkOutput("T2 best", best_score, 1);

        // T3: two interleaved full rows
        set_row(19, full_row(5'd2));
        set_row(18, a_row);
        set_row(17, full_row(5'd4));
        set_row(16, b_row);
        applyStimulus(-1, cyc, gaps, smid);
        checkOutput("T3 cycles", cyc, 43);
        checkOutput("T3 row19", map[19], a_row);
        checkOutput("T3 row18", map[18], b_row);
        n = 0;
        for (int r = 0; r < 18; r++) if (map[r] != '0) n++;
        checkOutput("T3 empty rows", n, 0);
        checkOutput("T3 lines", lines_cleared, 2);
        checkOutput("T3 score", score, 4);

        // Three-line pass then two single-line passes bring the score to 11
        fill_full(3);
        applyStimulus(-1, cyc, gaps, smid);
        checkOutput("3line lines", lines_cleared, 3);
        checkOutput("3line score", score, 9);
        fill_full(1);
        applyStimulus(-1, cyc, gaps, smid);
        fill_full(1);
        applyStimulus(-1, cyc, gaps, smid);
        checkOutput("T5 pre score", score, 11);

        // T5: new_game while idle
        new_game = 1'b1;
        @(negedge VGA_CLK);
        new_game = 1'b0;
        checkOutput("T5 ng score", score, 0);
        checkOutput("T5 ng best", best_score, 11);
        fill_full(1);
        applyStimulus(-1, cyc, gaps, smid);
        checkOutput("T5 score", score, 1);
        checkOutput("T5 best", best_score, 11);

        // T6: second start during a pass is ignored
        dn0 = done_count;
        cyc = -1;
        @(negedge VGA_CLK);
        start = 1'b1;
        @(posedge VGA_CLK);
        for (int i = 1; i <= 100; i++) begin
            @(negedge VGA_CLK);
            start = (i == 5);
            if (done) cyc = i;
        end
        checkOutput("T6 done cycle", cyc, 41);
        checkOutput("T6 done pulses", done_count - dn0, 1);
        checkOutput("T6 idle", busy, 0);

        // new_game in the DONE cycle: score cleared, best still updated
        fill_full(4);
        applyStimulus(-1, cyc, gaps, smid);
        checkOutput("4line cycles", cyc, 45);
        checkOutput("4line score", score, 9);
        fill_full(4);
        applyStimulus(0, cyc, gaps, smid);
        checkOutput("ngdone score", score, 0);
        checkOutput("ngdone best", best_score, 17);

        // new_game mid-pass: score cleared, pass still completes
        fill_full(1);
        applyStimulus(10, cyc, gaps, smid);
        checkOutput("ngmid score mid", smid, 0);
        checkOutput("ngmid cycles", cyc, 42);
        checkOutput("ngmid score", score, 1);
        checkOutput("ngmid best", best_score, 17);

        // T4: saturation at 9999
        new_game = 1'b1;
        @(negedge VGA_CLK);
        new_game = 1'b0;
        for (int p = 1; p <= 1251; p++) begin
            fill_full(4);
            applyStimulus(-1, cyc, gaps, smid);
            if (p == 1249) checkOutput("T4 score 1249", score, 9992);
            if (p == 1250) checkOutput("T4 score 1250", score, 9999);
            if (p == 1251) checkOutput("T4 score 1251", score, 9999);
        end
        checkOutput("T4 best", best_score, 9999);

        // T7: reset during CLR
        fill_full(4);
        @(negedge VGA_CLK);
        start = 1'b1;
        @(posedge VGA_CLK);
        repeat (42) begin
            @(negedge VGA_CLK);
            start = 1'b0;
        end
        checkOutput("T7 in CLR wr_en", wr_en, 1);
        checkOutput("T7 in CLR busy", busy, 1);
        #2 RESET = 1'b1;
        #1;
        checkOutput("T7 wr_en", wr_en, 0);
        checkOutput("T7 busy", busy, 0);
        checkOutput("T7 done", done, 0);
        checkOutput("T7 score", score, 0);
        checkOutput("T7 best", best_score, 0);
        @(negedge VGA_CLK);
        clear_map();
        RESET = 1'b0;
        @(negedge VGA_CLK);
        fill_full(1);
        applyStimulus(-1, cyc, gaps, smid);
        checkOutput("T7 after cycles", cyc, 42);
        checkOutput("T7 after score", score, 1);
        checkOutput("T7 after lines", lines_cleared, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
